// File: rtl/audio_stream_sequencer.sv
// Sample-rate control stage around a stereo moving-average filter pair: pops a codec
// sample, feeds both filters, applies saturating power-of-two gain and pushes the result.
module audio_stream_sequencer #(
  parameter int unsigned W          = 24,
  parameter int unsigned GAIN_SHIFT = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             read_ready,
  input  logic [W-1:0]     readdata_left,
  input  logic [W-1:0]     readdata_right,
  input  logic             write_ready,
  output logic             read,
  output logic             write,
  output logic [W-1:0]     writedata_left,
  output logic [W-1:0]     writedata_right,
  output logic             filt_en,
  output logic [W-1:0]     filt_in_left,
  output logic [W-1:0]     filt_in_right,
  input  logic [W-1:0]     filt_out_left,
  input  logic [W-1:0]     filt_out_right,
  input  logic             bypass,
  output logic [CNT_W-1:0] sample_count
);

  typedef enum logic [2:0] {
    StRdWait,
    StRead,
    StFilt,
    StSettle,
    StWrWait,
    StWrite
  } state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      filt_in_l_q, filt_in_l_d, filt_in_r_q, filt_in_r_d;
  logic [W-1:0]      wd_l_q, wd_l_d, wd_r_q, wd_r_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Shift in a W+8 bit domain so any legal gain (<= 7) cannot overflow before the clamp.
  function automatic logic [W-1:0] gain_sat(input logic [W-1:0] x);
    logic signed [W+7:0] ext;
    logic signed [W+7:0] max_v;
    logic signed [W+7:0] min_v;
    ext   = $signed({{8{x[W-1]}}, x}) <<< GAIN_SHIFT;
    max_v = $signed({9'b0, {(W-1){1'b1}}});
    min_v = $signed({9'h1ff, {(W-1){1'b0}}});
    if (ext > max_v) begin
      gain_sat = {1'b0, {(W-1){1'b1}}};
    end else if (ext < min_v) begin
      gain_sat = {1'b1, {(W-1){1'b0}}};
    end else begin
      gain_sat = ext[W-1:0];
    end
  endfunction

  always_comb begin
    state_d     = state_q;
    filt_in_l_d = filt_in_l_q;
    filt_in_r_d = filt_in_r_q;
    wd_l_d      = wd_l_q;
    wd_r_d      = wd_r_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      StRdWait: if (read_ready) state_d = StRead;
      StRead: begin
        filt_in_l_d = readdata_left;
        filt_in_r_d = readdata_right;
        state_d     = StFilt;
      end
      StFilt: state_d = StSettle;
      StSettle: begin
        // bypass is only looked at here, so toggling it elsewhere cannot disturb a sample.
        wd_l_d  = gain_sat(bypass ? filt_in_l_q : filt_out_left);
        wd_r_d  = gain_sat(bypass ? filt_in_r_q : filt_out_right);
        state_d = StWrWait;
      end
      StWrWait: if (write_ready) state_d = StWrite;
      StWrite: begin
        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        state_d = StRdWait;
      end
      default: state_d = StRdWait;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StRdWait;
      filt_in_l_q <= '0;
      filt_in_r_q <= '0;
      wd_l_q      <= '0;
      wd_r_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      filt_in_l_q <= filt_in_l_d;
      filt_in_r_q <= filt_in_r_d;
      wd_l_q      <= wd_l_d;
      wd_r_q      <= wd_r_d;
      cnt_q       <= cnt_d;
    end
  end

  assign read            = (state_q == StRead);
  assign filt_en         = (state_q == StFilt);
  assign write           = (state_q == StWrite);
  assign filt_in_left    = filt_in_l_q;
  assign filt_in_right   = filt_in_r_q;
  assign writedata_left  = wd_l_q;
  assign writedata_right = wd_r_q;
  assign sample_count    = cnt_q;

endmodule

// File: tb/tb_audio_stream_sequencer.sv
// Randomised scoreboard bench for audio_stream_sequencer with an 8-tap box filter model
// standing in for the external filters (GAIN_SHIFT=4, 8-bit counter to reach the wrap).
module tb_audio_stream_sequencer;
  localparam int W  = 24;
  localparam int GS = 4;
  localparam int CW = 8;
  localparam longint MAXV = (longint'(1) << (W - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (W - 1));

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          read_ready = 1'b0, write_ready = 1'b0, bypass = 1'b0;
  logic [W-1:0]  readdata_left = '0, readdata_right = '0;
  logic [W-1:0]  filt_out_left = '0, filt_out_right = '0;
  logic          read, write, filt_en;
  logic [W-1:0]  writedata_left, writedata_right, filt_in_left, filt_in_right;
  logic [CW-1:0] sample_count;

  always #5 clk = ~clk;

  audio_stream_sequencer #(.W(W), .GAIN_SHIFT(GS), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .read_ready(read_ready),
    .readdata_left(readdata_left), .readdata_right(readdata_right),
    .write_ready(write_ready), .read(read), .write(write),
    .writedata_left(writedata_left), .writedata_right(writedata_right),
    .filt_en(filt_en), .filt_in_left(filt_in_left), .filt_in_right(filt_in_right),
    .filt_out_left(filt_out_left), .filt_out_right(filt_out_right),
    .bypass(bypass), .sample_count(sample_count)
  );

  // External filter: mean of the last 8 samples, registered one cycle after filt_en.
  logic signed [W-1:0] fh_l[8] = '{default: '0};
  logic signed [W-1:0] fh_r[8] = '{default: '0};
  always @(posedge clk) begin : filt_model
    int sl, sr;
    if (filt_en === 1'b1) begin
      for (int i = 7; i > 0; i--) begin
        fh_l[i] = fh_l[i-1];
        fh_r[i] = fh_r[i-1];
      end
      fh_l[0] = filt_in_left;
      fh_r[0] = filt_in_right;
      sl = 0;
      sr = 0;
      for (int i = 0; i < 8; i++) begin
        sl += int'(fh_l[i]);
        sr += int'(fh_r[i]);
      end
      filt_out_left  <= W'(sl >>> 3);
      filt_out_right <= W'(sr >>> 3);
    end
  end

  int n_chk = 0, n_fail = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {logic [W-1:0] l; logic [W-1:0] r;} exp_t;
  exp_t exp_q[$];
  int   hl[$], hr[$];

  int   rr_mode, wr_mode, byp_mode, data_mode, lat_mode;
  int   byp_cnt = 0;
  logic pend_byp = 1'b0;
  int   n_wr = 0;

  function automatic logic [W-1:0] sat_ref(input int v);
    longint     t;
    logic [63:0] b;
    t = longint'(v) * (longint'(1) << GS);
    if (t > MAXV) t = MAXV;
    if (t < MINV) t = MINV;
    b = t;
    return b[W-1:0];
  endfunction

  function automatic int mean8(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s >>> 3;
  endfunction

  function automatic logic [W-1:0] rand_sample();
    logic [W-1:0] v;
    if ($urandom_range(0, 2) == 0) return W'($urandom);
    v = W'($urandom_range(0, 1 << 20));
    return v - W'(1 << 19);
  endfunction

  // Called when the DUT pops a sample: record history and queue the expected output.
  task automatic consume();
    int   xl, xr;
    exp_t e;
    check("one_sample_in_flight", 64'(exp_q.size()), 64'd0);
    xl = int'($signed(readdata_left));
    xr = int'($signed(readdata_right));
    hl.push_back(xl);
    hr.push_back(xr);
    if (hl.size() > 8) void'(hl.pop_front());
    if (hr.size() > 8) void'(hr.pop_front());
    pend_byp = (byp_mode == 2) ? 1'b1 : (byp_mode == 1) ? 1'b0 : 1'($urandom);
    e.l = sat_ref(pend_byp ? xl : mean8(hl));
    e.r = sat_ref(pend_byp ? xr : mean8(hr));
    exp_q.push_back(e);
    byp_cnt = 2;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    if (byp_cnt != 0) begin
      byp_cnt--;
      bypass = (byp_cnt == 0) ? pend_byp : 1'($urandom);
    end else begin
      bypass = 1'($urandom);
    end
    if (read === 1'b1) consume();
    else begin
      if (data_mode == 1) begin
        readdata_left  = rand_sample();
        readdata_right = rand_sample();
      end
      read_ready = (rr_mode == 2) ? ($urandom_range(0, 3) != 0) : (rr_mode != 0);
    end
    write_ready = (wr_mode == 2) ? ($urandom_range(0, 2) != 0) : (wr_mode != 0);
  endtask

  task automatic run_samples(input int n);
    int target, budget;
    target = n_wr + n;
    budget = n * 60 + 100;
    while (n_wr < target && budget > 0) begin
      tick();
      budget--;
    end
    check("samples_done_in_time", 64'(n_wr >= target), 64'd1);
  endtask

  // Monitor: pops the scoreboard on every write and checks strobe protocol.
  int         cyc = 0, last_read_cyc = 0, model_cnt = 0;
  logic       prev_read = 1'b0;
  exp_t       got;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        prev_read = 1'b0;
        model_cnt = 0;
      end else begin
        if (read || write || filt_en)
          check("strobes_exclusive", 64'(int'(read) + int'(write) + int'(filt_en)), 64'd1);
        if (filt_en || prev_read) check("filt_en_after_read", 64'(filt_en), 64'(prev_read));
        if (read) last_read_cyc = cyc;
        if (write) begin
          check("write_ready_before_write", 64'(write_ready), 64'd1);
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_write: got write with empty scoreboard, expected none");
          end else begin
            got = exp_q.pop_front();
            check("writedata_left", 64'(writedata_left), 64'(got.l));
            check("writedata_right", 64'(writedata_right), 64'(got.r));
          end
          check("sample_count_at_write", 64'(sample_count), 64'(model_cnt));
          model_cnt = (model_cnt + 1) % (1 << CW);
          if (lat_mode != 0) check("read_to_write_latency", 64'(cyc - last_read_cyc), 64'd4);
          n_wr++;
        end
        prev_read = read;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int strobes;
    logic [W-1:0]  hold_l, hold_r;
    logic [CW-1:0] cnt0, cnt1;
    int budget;
    for (int i = 0; i < 8; i++) begin
      hl.push_back(0);
      hr.push_back(0);
    end
    rr_mode = 1; wr_mode = 1; byp_mode = 1; data_mode = 0; lat_mode = 1;
    readdata_left = W'(8); readdata_right = W'(8);
    read_ready = 1'b1; write_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_read", 64'(read), 64'd0);
    check("rst_write", 64'(write), 64'd0);
    check("rst_filt_en", 64'(filt_en), 64'd0);
    check("rst_filt_in", 64'({filt_in_left, filt_in_right}), 64'd0);
    check("rst_writedata", 64'({writedata_left, writedata_right}), 64'd0);
    check("rst_count", 64'(sample_count), 64'd0);
    #1 reset = 1'b1;

    // Constant 8 through the filter: outputs 1..8 (times 16 gain), then hold.
    run_samples(10);
    tick();
    check("count_after_10", 64'(sample_count), 64'd10);

    // Back-pressure: hold write_ready low with a sample in flight.
    lat_mode = 0; data_mode = 1; byp_mode = 0;
    run_samples(2);
    wr_mode = 0;
    repeat (6) tick();
    hold_l = writedata_left;
    hold_r = writedata_right;
    cnt0 = sample_count;
    strobes = 0;
    repeat (20) begin
      tick();
      strobes += int'(read) + int'(filt_en) + int'(write);
    end
    check("stall_no_strobes", 64'(strobes), 64'd0);
    check("stall_hold_data", 64'({writedata_left, writedata_right}), 64'({hold_l, hold_r}));
    check("stall_one_pending", 64'(exp_q.size()), 64'd1);
    wr_mode = 1;
    write_ready = 1'b1;
    tick();
    check("write_after_release", 64'(write), 64'd1);
    tick();
    cnt1 = cnt0 + 1'b1;
    check("count_after_release", 64'(sample_count), 64'(cnt1));

    // Gain/saturation corners through bypass.
    run_samples(1);
    data_mode = 0; byp_mode = 2; lat_mode = 1;
    readdata_left = 24'h07FFFF; readdata_right = 24'hF80000;
    run_samples(1);
    check("gain_exact_left", 64'(writedata_left), 64'h7FFFF0);
    check("gain_exact_right", 64'(writedata_right), 64'h800000);
    readdata_left = 24'h100000; readdata_right = 24'hE00000;
    run_samples(1);
    check("sat_pos", 64'(writedata_left), 64'h7FFFFF);
    check("sat_neg", 64'(writedata_right), 64'h800000);

    // Random traffic, long enough to wrap the counter.
    lat_mode = 0; data_mode = 1; byp_mode = 0; rr_mode = 2; wr_mode = 2;
    run_samples(300);

    // Asynchronous reset while in FILT.
    rr_mode = 1; wr_mode = 1;
    budget = 50;
    while (filt_en !== 1'b1 && budget > 0) begin
      tick();
      budget--;
    end
    check("reached_filt", 64'(filt_en), 64'd1);
    reset = 1'b0;
    #1;
    check("async_rst_filt_en", 64'(filt_en), 64'd0);
    check("async_rst_strobes", 64'({read, write}), 64'd0);
    check("async_rst_data", 64'({filt_in_left, filt_in_right}), 64'd0);
    check("async_rst_wdata", 64'({writedata_left, writedata_right}), 64'd0);
    check("async_rst_count", 64'(sample_count), 64'd0);
    exp_q.delete();
    byp_cnt = 0;
    rr_mode = 0;
    read_ready = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    strobes = 0;
    repeat (6) begin
      tick();
      strobes += int'(read) + int'(filt_en) + int'(write);
    end
    check("idle_without_read_ready", 64'(strobes), 64'd0);
    rr_mode = 1; byp_mode = 2; lat_mode = 1;
    run_samples(3);
    tick();
    check("count_after_reset", 64'(sample_count), 64'd3);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
